// File: rtl/auto_opponent.sv
// Automatic P2 player: snapshots the board on its turn, scans the eight lines,
// picks win > block > centre > corner > edge, then plays and waits for the mark.
module auto_opponent #(
  parameter int THINK_CYCLES = 4,
  parameter int HOLD_CYCLES  = 2,
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] pos0,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] winner,
  output logic       p2,
  output logic [3:0] p2_pos,
  output logic       busy,
  output logic       move_err
);

  localparam int MAXA = (THINK_CYCLES > HOLD_CYCLES) ? THINK_CYCLES : HOLD_CYCLES;
  localparam int MAXV = (MAXA > WAIT_TIMEOUT) ? MAXA : WAIT_TIMEOUT;
  localparam int CW   = (MAXV > 1) ? $clog2(MAXV + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DECIDE, S_THINK, S_PLAY, S_WAIT} state_t;

  state_t          r_state, w_next;
  logic [1:0]      r_snap [9];
  logic [3:0]      r_snap_n10;
  logic [2:0]      r_line;
  logic            r_win_vld, r_blk_vld;
  logic [3:0]      r_win_cell, r_blk_cell, r_choice, r_p2_pos;
  logic [CW-1:0]   r_cnt;
  logic            r_move_err;

  logic [1:0]      w_cells [9];
  logic [3:0]      w_n01, w_n10;
  logic            w_any_empty, w_turn, w_abort, w_err;
  logic [3:0]      w_a, w_b, w_c, w_line_empty, w_choice;
  logic [1:0]      w_l10, w_l01, w_l00;
  logic            w_line_win, w_line_blk;

  assign w_cells = '{pos0, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8};

  function automatic logic [11:0] line_cells(input logic [2:0] l);
    case (l)
      3'd0:    return {4'd0, 4'd1, 4'd2};
      3'd1:    return {4'd3, 4'd4, 4'd5};
      3'd2:    return {4'd6, 4'd7, 4'd8};
      3'd3:    return {4'd0, 4'd3, 4'd6};
      3'd4:    return {4'd1, 4'd4, 4'd7};
      3'd5:    return {4'd2, 4'd5, 4'd8};
      3'd6:    return {4'd0, 4'd4, 4'd8};
      default: return {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  always_comb begin
    w_n01       = '0;
    w_n10       = '0;
    w_any_empty = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (w_cells[i] == 2'b01) w_n01 = w_n01 + 4'd1;
      if (w_cells[i] == 2'b10) w_n10 = w_n10 + 4'd1;
      if (w_cells[i] == 2'b00) w_any_empty = 1'b1;
    end
  end

  assign w_turn  = enable && (winner == 2'b00) && w_any_empty && (w_n01 == w_n10 + 4'd1);
  assign w_abort = !enable || (winner != 2'b00);

  // Line evaluation always reads the snapshot, never the live board.
  always_comb begin
    {w_a, w_b, w_c} = line_cells(r_line);
    w_l10 = 2'(r_snap[w_a] == 2'b10) + 2'(r_snap[w_b] == 2'b10) + 2'(r_snap[w_c] == 2'b10);
    w_l01 = 2'(r_snap[w_a] == 2'b01) + 2'(r_snap[w_b] == 2'b01) + 2'(r_snap[w_c] == 2'b01);
    w_l00 = 2'(r_snap[w_a] == 2'b00) + 2'(r_snap[w_b] == 2'b00) + 2'(r_snap[w_c] == 2'b00);
    if (r_snap[w_a] == 2'b00)      w_line_empty = w_a;
    else if (r_snap[w_b] == 2'b00) w_line_empty = w_b;
    else                           w_line_empty = w_c;
    w_line_win = (w_l10 == 2'd2) && (w_l00 == 2'd1);
    w_line_blk = (w_l01 == 2'd2) && (w_l00 == 2'd1);
  end

  always_comb begin
    w_choice = 4'd0;
    if (r_win_vld)                w_choice = r_win_cell;
    else if (r_blk_vld)           w_choice = r_blk_cell;
    else if (r_snap[4] == 2'b00)  w_choice = 4'd4;
    else if (r_snap[0] == 2'b00)  w_choice = 4'd0;
    else if (r_snap[2] == 2'b00)  w_choice = 4'd2;
    else if (r_snap[6] == 2'b00)  w_choice = 4'd6;
    else if (r_snap[8] == 2'b00)  w_choice = 4'd8;
    else if (r_snap[1] == 2'b00)  w_choice = 4'd1;
    else if (r_snap[3] == 2'b00)  w_choice = 4'd3;
    else if (r_snap[5] == 2'b00)  w_choice = 4'd5;
    else if (r_snap[7] == 2'b00)  w_choice = 4'd7;
  end

  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    case (r_state)
      S_IDLE:   if (w_turn) w_next = S_SCAN;
      S_SCAN:   if (w_abort) w_next = S_IDLE;
                else if (r_line == 3'd7) w_next = S_DECIDE;
      S_DECIDE: if (w_abort) w_next = S_IDLE;
                else w_next = (THINK_CYCLES == 0) ? S_PLAY : S_THINK;
      S_THINK:  if (w_abort) w_next = S_IDLE;
                else if (r_cnt == '0) w_next = S_PLAY;
      S_PLAY:   if (w_abort) w_next = S_IDLE;
                else if (r_cnt == '0) w_next = S_WAIT;
      S_WAIT:   if (w_n10 == r_snap_n10 + 4'd1) w_next = S_IDLE;
                else if (r_cnt == '0) begin
                  w_next = S_IDLE;
                  w_err  = 1'b1;
                end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_snap     <= '{default: 2'b00};
      r_snap_n10 <= '0;
      r_line     <= '0;
      r_win_vld  <= 1'b0;
      r_blk_vld  <= 1'b0;
      r_win_cell <= '0;
      r_blk_cell <= '0;
      r_choice   <= '0;
      r_p2_pos   <= '0;
      r_cnt      <= '0;
      r_move_err <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_move_err <= w_err;
      if (r_state == S_IDLE && w_next == S_SCAN) begin
        r_snap     <= w_cells;
        r_snap_n10 <= w_n10;
        r_line     <= '0;
        r_win_vld  <= 1'b0;
        r_blk_vld  <= 1'b0;
      end
      if (r_state == S_SCAN) begin
        if (r_line != 3'd7) r_line <= r_line + 3'd1;
        if (w_line_win && !r_win_vld) begin
          r_win_vld  <= 1'b1;
          r_win_cell <= w_line_empty;
        end
        if (w_line_blk && !r_blk_vld) begin
          r_blk_vld  <= 1'b1;
          r_blk_cell <= w_line_empty;
        end
      end
      if (r_state == S_DECIDE) r_choice <= w_choice;
      // DECIDE can jump straight to PLAY, so take the combinational choice there.
      if (w_next == S_PLAY && r_state != S_PLAY)
        r_p2_pos <= (r_state == S_DECIDE) ? w_choice : r_choice;
      if (w_next != r_state) begin
        case (w_next)
          S_THINK: r_cnt <= CW'(THINK_CYCLES - 1);
          S_PLAY:  r_cnt <= CW'(HOLD_CYCLES - 1);
          S_WAIT:  r_cnt <= CW'(WAIT_TIMEOUT - 1);
          default: r_cnt <= '0;
        endcase
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign p2       = (r_state == S_PLAY);
  assign p2_pos   = r_p2_pos;
  assign busy     = (r_state != S_IDLE);
  assign move_err = r_move_err;

endmodule

// File: tb/tb_auto_opponent.sv
// Scenario bench for auto_opponent: expected plays are queued when a board is
// driven and checked (cell, latency, hold) when p2 rises.
module tb_auto_opponent;

  logic       clk = 1'b0;
  logic       reset, enable;
  logic [1:0] brd [9];
  logic [1:0] winner;
  logic       p2, busy, move_err;
  logic [3:0] p2_pos;

  typedef struct {
    logic [3:0] pos;
    int         lat;
  } exp_t;

  exp_t sb [$];
  int   checks = 0;
  int   fails  = 0;
  int   err_seen = 0;

  always #5 clk = ~clk;

  auto_opponent dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pos0(brd[0]), .pos1(brd[1]), .pos2(brd[2]), .pos3(brd[3]), .pos4(brd[4]),
    .pos5(brd[5]), .pos6(brd[6]), .pos7(brd[7]), .pos8(brd[8]),
    .winner(winner), .p2(p2), .p2_pos(p2_pos), .busy(busy), .move_err(move_err)
  );

  always @(negedge clk) if (move_err === 1'b1) err_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_board();
    for (int i = 0; i < 9; i++) brd[i] = 2'b00;
  endtask

  task automatic push_exp(input logic [3:0] pos, input int lat);
    exp_t e;
    e.pos = pos;
    e.lat = lat;
    sb.push_back(e);
  endtask

  // Latency is counted in negedges from the current one.
  task automatic check_play(input string name, input bit follow_hold);
    exp_t e;
    int   k;
    int   h;
    bit   seen;
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s_sb: scoreboard empty, got=0 want=1 entries", name);
      return;
    end
    e = sb.pop_front();
    k = 0;
    seen = 1'b0;
    while (!seen && k < e.lat + 8) begin
      @(negedge clk);
      k++;
      if (p2 === 1'b1) seen = 1'b1;
    end
    if (!seen || k !== e.lat) begin
      fails++;
      $display("FAIL %s_lat: got=%0d (seen=%0d) want=%0d", name, k, seen, e.lat);
    end
    checks++;
    if (p2_pos !== e.pos) begin
      fails++;
      $display("FAIL %s_pos: got=%0d want=%0d", name, p2_pos, e.pos);
    end
    if (follow_hold) begin
      h = 0;
      while (p2 === 1'b1 && h < 10) begin
        @(negedge clk);
        h++;
      end
      checks++;
      if (h !== 2) begin
        fails++;
        $display("FAIL %s_hold: got=%0d want=2", name, h);
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy === 1'b1 && k < 5);
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle: busy got=%b want=0", name, busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (p2 !== 1'b0)       begin fails++; $display("FAIL rst_p2: got=%b want=0", p2); end
    checks++; if (p2_pos !== 4'd0)   begin fails++; $display("FAIL rst_pos: got=%0d want=0", p2_pos); end
    checks++; if (busy !== 1'b0)     begin fails++; $display("FAIL rst_busy: got=%b want=0", busy); end
    checks++; if (move_err !== 1'b0) begin fails++; $display("FAIL rst_err: got=%b want=0", move_err); end
    reset = 1'b1;
  endtask

  task automatic test_open_center();
    @(negedge clk);
    clear_board();
    brd[4] = 2'b01;
    push_exp(4'd0, 14);
    check_play("center", 1'b1);
    brd[0] = 2'b10;
    wait_idle("center");
    checks++;
    if (err_seen !== 0) begin
      fails++;
      $display("FAIL center_err: move_err pulses got=%0d want=0", err_seen);
    end
  endtask

  task automatic test_win_over_block();
    @(negedge clk);
    clear_board();
    brd[3] = 2'b01; brd[4] = 2'b01; brd[8] = 2'b01;
    brd[0] = 2'b10; brd[1] = 2'b10;
    push_exp(4'd2, 14);
    check_play("win", 1'b1);
    brd[2] = 2'b10;
    wait_idle("win");
  endtask

  task automatic test_block();
    @(negedge clk);
    clear_board();
    brd[0] = 2'b01; brd[1] = 2'b01; brd[4] = 2'b10;
    push_exp(4'd2, 14);
    check_play("block", 1'b1);
    brd[2] = 2'b10;
    wait_idle("block");
  endtask

  task automatic test_snapshot();
    @(negedge clk);
    clear_board();
    brd[6] = 2'b01; brd[7] = 2'b01; brd[0] = 2'b10;
    repeat (2) @(negedge clk);
    brd[8] = 2'b11;
    push_exp(4'd8, 12);
    check_play("snap", 1'b1);
    brd[8] = 2'b10;
    wait_idle("snap");
  endtask

  task automatic test_move_err();
    int k;
    int pulses;
    @(negedge clk);
    clear_board();
    brd[4] = 2'b01;
    push_exp(4'd0, 14);
    check_play("err_first", 1'b1);
    k = 0;
    while (move_err !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== 16) begin
      fails++;
      $display("FAIL err_time: got=%0d want=16 cycles after WAIT entry", k);
    end
    @(negedge clk);
    pulses = (move_err === 1'b1) ? 2 : 1;
    checks++;
    if (pulses !== 1) begin
      fails++;
      $display("FAIL err_width: got=%0d want=1 cycles", pulses);
    end
    push_exp(4'd0, 13);
    check_play("err_replay", 1'b1);
    brd[0] = 2'b10;
    wait_idle("err_replay");
  endtask

  task automatic test_abort();
    int seen_p2;
    @(negedge clk);
    clear_board();
    brd[4] = 2'b01;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_scan: busy got=%b want=1", busy);
    end
    winner = 2'b01;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: busy got=%b want=0", busy);
    end
    seen_p2 = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (p2 === 1'b1 || busy === 1'b1) seen_p2++;
    end
    checks++;
    if (seen_p2 !== 0) begin
      fails++;
      $display("FAIL abort_quiet: active cycles got=%0d want=0", seen_p2);
    end
    clear_board();
    winner = 2'b00;
  endtask

  task automatic test_reset_mid_play();
    @(negedge clk);
    clear_board();
    brd[0] = 2'b01; brd[1] = 2'b01; brd[4] = 2'b10;
    push_exp(4'd2, 14);
    check_play("midplay", 1'b0);
    reset = 1'b0;
    clear_board();
    @(negedge clk);
    checks++; if (p2 !== 1'b0)     begin fails++; $display("FAIL midrst_p2: got=%b want=0", p2); end
    checks++; if (p2_pos !== 4'd0) begin fails++; $display("FAIL midrst_pos: got=%0d want=0", p2_pos); end
    checks++; if (busy !== 1'b0)   begin fails++; $display("FAIL midrst_busy: got=%b want=0", busy); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b1;
    winner = 2'b00;
    clear_board();
    test_reset();
    test_open_center();
    test_win_over_block();
    test_block();
    test_snapshot();
    test_move_err();
    test_abort();
    test_reset_mid_play();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/auto_opponent.md
AUTO_OPPONENT -- requirements
Module: auto_opponent

Interface
REQ-001 The block SHALL have parameter THINK_CYCLES, default 4: number of idle cycles between the move decision and asserting p2.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 2: number of cycles p2 and p2_pos are held asserted.
REQ-003 The block SHALL have parameter WAIT_TIMEOUT, default 16: number of cycles to wait for the board to show the P2 mark before flagging rejection.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 enable  input  1  1 = the block plays as P2; 0 = the block stays passive.
REQ-007 pos0..pos8  input  2 each  live board cells, numbered row-major (0 = top-left): 00 empty, 01 P1, 10 P2, 11 occupied-invalid.
REQ-008 winner  input  2  00 = no winner, 01 = P1, 10 = P2.
REQ-009 p2  output  1  P2 play select, driven to the turn FSM.
REQ-010 p2_pos  output  4  chosen cell index 0-8, driven to the P2 position decoder.
REQ-011 busy  output  1  1 whenever the FSM is not in IDLE.
REQ-012 move_err  output  1  one-cycle pulse when a played move is not reflected on the board.

Function
REQ-013 The FSM SHALL use the states IDLE, SCAN, DECIDE, THINK, PLAY and WAIT.
REQ-014 Turn condition: enable=1, winner=00, at least one 00 cell, and (count of 01 cells) = (count of 10 cells)+1. Cells holding 11 count as neither mark and are not empty.
REQ-015 IDLE: when the turn condition holds, the FSM SHALL snapshot all nine cells and the 10-count, then go to SCAN on the next cycle.
REQ-016 SCAN SHALL last exactly 8 cycles and evaluate one line per cycle from the snapshot, in this order: rows 0-1-2, 3-4-5, 6-7-8; columns 0-3-6, 1-4-7, 2-5-8; diagonals 0-4-8, 2-4-6.
REQ-017 Win candidate: the first line holding two 10 cells and one 00 cell; the candidate cell is that 00 cell.
REQ-018 Block candidate: the first line holding two 01 cells and one 00 cell; the candidate cell is that 00 cell.
REQ-019 DECIDE (1 cycle) SHALL choose the move by priority: win candidate, then block candidate, then cell 4 if empty, then the first empty corner in order 0, 2, 6, 8, then the first empty edge in order 1, 3, 5, 7.
REQ-020 THINK SHALL last THINK_CYCLES cycles; with THINK_CYCLES=0 the FSM SHALL go from DECIDE directly to PLAY.
REQ-021 PLAY SHALL hold p2=1 and p2_pos=chosen cell for exactly HOLD_CYCLES cycles, then go to WAIT with p2=0.
REQ-022 Latency: with the turn condition detected in IDLE at cycle T, p2 SHALL first be 1 at cycle T+10+THINK_CYCLES.
REQ-023 p2_pos SHALL hold its last value outside PLAY; p2 SHALL be 1 only in PLAY.
REQ-024 WAIT: when the live 10-count equals the snapshot 10-count plus 1, the FSM SHALL return to IDLE.
REQ-025 WAIT timeout: if that count is not reached within WAIT_TIMEOUT cycles, move_err SHALL pulse for 1 cycle and the FSM SHALL return to IDLE; the block then retries if the turn condition still holds.
REQ-026 Abort: in SCAN, DECIDE, THINK or PLAY, if enable=0 or winner!=00, the FSM SHALL go to IDLE on the next edge, with p2=0 from that edge.
REQ-027 The live board changing during SCAN or THINK SHALL NOT alter the decision; the decision uses the snapshot only.
REQ-028 All internal counters SHALL be sized for their parameter values and SHALL NOT wrap.

Reset
REQ-029 reset=0 at a clock edge SHALL force: state IDLE, p2=0, p2_pos=0, busy=0, move_err=0, and clear all counters and snapshots, regardless of the current state.
REQ-030 The first possible transition out of IDLE SHALL be on the first edge after reset returns to 1.

Verification
REQ-031 Reset in mid-PLAY: reset=0 for 1 edge -> p2=0, p2_pos=0, busy=0 on that edge.
REQ-032 P1 at cell 4 only, enable=1 -> p2=1 with p2_pos=0 at T+14 (defaults), held 2 cycles.
REQ-033 P1 at 3, 4, 8 and P2 at 0, 1 (win and block both available) -> p2_pos=2 (win beats block).
REQ-034 P1 at 0, 1 and P2 at 4 -> p2_pos=2 (block).
REQ-035 Board left unchanged after PLAY -> move_err=1 for exactly 1 cycle, 16 cycles after entering WAIT; the block then replays the same cell.
REQ-036 winner set to 01 during SCAN -> IDLE on the next edge; p2 is never asserted.
